// File: rtl/pcie3_cfg_mesg_tx_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters onto the PCIe cfg message TX port.
// Optional SEND timeout is enabled by defining PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN.
module pcie3_cfg_mesg_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_REQ-1:0]    s_req_valid,
  input  logic [3*NUM_REQ-1:0]  s_req_type,
  input  logic [32*NUM_REQ-1:0] s_req_data,
  output logic [NUM_REQ-1:0]    s_req_done,
  output logic [NUM_REQ-1:0]    s_req_err,
  output logic                  m_transmit,
  output logic [2:0]            m_transmit_type,
  output logic [31:0]           m_transmit_data,
  input  logic                  m_transmit_done,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic                  spurious_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t               state_q, state_d;
  logic                 m_transmit_q, m_transmit_d;
  logic [2:0]           type_q, type_d;
  logic [31:0]          data_q, data_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic                 spurious_q, spurious_d;

`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
`endif

  always_comb begin
    int   idx;
    int   win;
    logic found;
    state_d      = state_q;
    m_transmit_d = m_transmit_q;
    type_d       = type_q;
    data_d       = data_q;
    done_d       = '0;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    busy_d       = busy_q;
    // Done from the core outside SEND is never used for sequencing, only flagged.
    spurious_d   = spurious_q | (m_transmit_done && (state_q != SEND));
`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = '0;
`endif

    // Search starts at rr_ptr and wraps, so the first valid hit is the round-robin winner.
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && s_req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = SEND;
          m_transmit_d = 1'b1;
          busy_d       = 1'b1;
          type_d       = s_req_type[win*3 +: 3];
          data_d       = s_req_data[win*32 +: 32];
          grant_d      = 3'(win);
          rr_ptr_d     = (win == NUM_REQ-1) ? 3'd0 : 3'(win + 1);
`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      SEND: begin
        if (m_transmit_done) begin
          state_d      = DONE;
          m_transmit_d = 1'b0;
          done_d       = NUM_REQ'(1) << grant_q;
        end
`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
          state_d      = DONE;
          m_transmit_d = 1'b0;
          done_d       = NUM_REQ'(1) << grant_q;
          err_d        = NUM_REQ'(1) << grant_q;
        end else begin
          cnt_d        = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        m_transmit_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      m_transmit_q <= 1'b0;
      type_q       <= '0;
      data_q       <= '0;
      done_q       <= '0;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= 1'b0;
      spurious_q   <= 1'b0;
`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      m_transmit_q <= m_transmit_d;
      type_q       <= type_d;
      data_q       <= data_d;
      done_q       <= done_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      spurious_q   <= spurious_d;
`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign m_transmit      = m_transmit_q;
  assign m_transmit_type = type_q;
  assign m_transmit_data = data_q;
  assign s_req_done      = done_q;
  assign busy            = busy_q;
  assign grant_id        = grant_q;
  assign spurious_done   = spurious_q;
`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
  assign s_req_err       = err_q;
`else
  assign s_req_err       = '0;
`endif

endmodule

// File: tb/tb_pcie3_cfg_mesg_tx_arbiter.sv
// Bench for pcie3_cfg_mesg_tx_arbiter: directed and randomized messages checked
// against a transaction-level round-robin model.
module tb_pcie3_cfg_mesg_tx_arbiter;
  localparam int N = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    s_req_valid;
  logic [3*N-1:0]  s_req_type;
  logic [32*N-1:0] s_req_data;
  logic [N-1:0]    s_req_done;
  logic [N-1:0]    s_req_err;
  logic            m_transmit;
  logic [2:0]      m_transmit_type;
  logic [31:0]     m_transmit_data;
  logic            m_transmit_done;
  logic            busy;
  logic [2:0]      grant_id;
  logic            spurious_done;

  int   vectors     = 0;
  int   miscompares = 0;
  int   rr          = 0;
  logic exp_spur    = 1'b0;

  pcie3_cfg_mesg_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_req_valid     (s_req_valid),
    .s_req_type      (s_req_type),
    .s_req_data      (s_req_data),
    .s_req_done      (s_req_done),
    .s_req_err       (s_req_err),
    .m_transmit      (m_transmit),
    .m_transmit_type (m_transmit_type),
    .m_transmit_data (m_transmit_data),
    .m_transmit_done (m_transmit_done),
    .busy            (busy),
    .grant_id        (grant_id),
    .spurious_done   (spurious_done)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      s_req_data[32*i +: 32] = $urandom;
      s_req_type[3*i +: 3]   = 3'($urandom_range(0, 7));
    end
  endtask

  // Reference round robin: first valid requester at or after the priority pointer.
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  // Full message: grant, `hold` extra SEND cycles, core done, DONE, back to IDLE.
  task automatic do_msg(input logic [N-1:0] v, input int hold, input logic [N-1:0] next_v);
    int          w;
    logic [2:0]  et;
    logic [31:0] ed;
    s_req_valid = v;
    w  = pick(v);
    et = s_req_type[3*w +: 3];
    ed = s_req_data[32*w +: 32];
    tick();
    chk("xmit_rise", m_transmit, 1);
    chk("grant", grant_id, w);
    chk("type_cap", m_transmit_type, et);
    chk("data_cap", m_transmit_data, ed);
    chk("busy_send", busy, 1);
    chk("done_in_send", s_req_done, 0);
    rr = (w + 1) % N;
    for (int i = 0; i < hold; i++) begin
      scramble();
      if ($urandom_range(0, 1) == 1) s_req_valid = '0;
      tick();
      chk("xmit_hold", m_transmit, 1);
      chk("data_hold", m_transmit_data, ed);
      chk("type_hold", m_transmit_type, et);
    end
    m_transmit_done = 1'b1;
    tick();
    m_transmit_done = 1'b0;
    chk("done_pulse", s_req_done, 32'd1 << w);
    chk("err_clear", s_req_err, 0);
    chk("xmit_fall", m_transmit, 0);
    chk("busy_done", busy, 1);
    s_req_valid = next_v;
    scramble();
    tick();
    chk("done_single", s_req_done, 0);
    chk("busy_idle", busy, 0);
    chk("xmit_idle", m_transmit, 0);
    chk("spurious", spurious_done, exp_spur);
  endtask

  initial begin
    aresetn         = 1'b0;
    s_req_valid     = '0;
    s_req_type      = '0;
    s_req_data      = '0;
    m_transmit_done = 1'b0;
    #12;
    chk("rst_xmit", m_transmit, 0);
    chk("rst_type", m_transmit_type, 0);
    chk("rst_data", m_transmit_data, 0);
    chk("rst_done", s_req_done, 0);
    chk("rst_err", s_req_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_spur", spurious_done, 0);
    tick();
    aresetn = 1'b1;
    tick();

    // Single request with a fixed payload, 5 SEND cycles.
    s_req_type[2:0]  = 3'b010;
    s_req_data[31:0] = 32'hDEADBEEF;
    do_msg(4'b0001, 4, 4'b0000);

    // Core done while idle: flagged, no message starts.
    m_transmit_done = 1'b1;
    tick();
    m_transmit_done = 1'b0;
    exp_spur = 1'b1;
    chk("spur_set", spurious_done, 1);
    chk("spur_busy", busy, 0);
    chk("spur_xmit", m_transmit, 0);
    tick();
    chk("spur_sticky", spurious_done, 1);
    chk("spur_nodone", s_req_done, 0);

    // Requester 2 changes its payload during SEND.
    scramble();
    do_msg(4'b0100, 5, 4'b0000);

    // Reset asserted in the third SEND cycle.
    scramble();
    s_req_valid = 4'b1000;
    tick();
    chk("rst_send_xmit", m_transmit, 1);
    tick();
    tick();
    aresetn     = 1'b0;
    s_req_valid = '0;
    #1;
    chk("rst_abort_xmit", m_transmit, 0);
    chk("rst_abort_busy", busy, 0);
    chk("rst_abort_done", s_req_done, 0);
    chk("rst_abort_spur", spurious_done, 0);
    chk("rst_abort_grant", grant_id, 0);
    exp_spur = 1'b0;
    rr       = 0;
    tick();
    aresetn = 1'b1;
    tick();
    chk("rst_rel_done", s_req_done, 0);
    chk("rst_rel_busy", busy, 0);

    // All requesters continuously valid: expect 0,1,2,3,0.
    scramble();
    for (int m = 0; m < 5; m++) begin
      chk("rr_order_ptr", rr, (m % N));
      do_msg(4'b1111, 2, (m == 4) ? 4'b0000 : 4'b1111);
    end

`ifdef PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN
    begin
      int w;
      scramble();
      s_req_valid = 4'b0011;
      w = pick(4'b0011);
      tick();
      chk("to_grant", grant_id, w);
      rr = (w + 1) % N;
      for (int i = 0; i < 15; i++) begin
        chk("to_xmit", m_transmit, 1);
        chk("to_nodone", s_req_done, 0);
        tick();
      end
      chk("to_last_xmit", m_transmit, 1);
      tick();
      chk("to_done", s_req_done, 32'd1 << w);
      chk("to_err", s_req_err, 32'd1 << w);
      chk("to_xmit_fall", m_transmit, 0);
      tick();
      chk("to_err_clear", s_req_err, 0);
      do_msg(4'b0011, 1, 4'b0000);
    end
`endif

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      scramble();
      do_msg(N'($urandom_range(1, 15)), $urandom_range(0, 5), 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcie3_cfg_mesg_tx_arbiter.md
PCIE3_CFG_MESG_TX_ARBITER -- requirements
Module: pcie3_cfg_mesg_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SEND-state cycle limit (used only with the timeout feature).
REQ-003 aclk  input  1  sole clock; all logic rising-edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 s_req_valid  input  NUM_REQ  per-requester message request, level.
REQ-006 s_req_type  input  3*NUM_REQ  message type; slice i = [3i+2:3i].
REQ-007 s_req_data  input  32*NUM_REQ  message data; slice i = [32i+31:32i].
REQ-008 s_req_done  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-009 s_req_err  output  NUM_REQ  one-cycle timeout pulse, coincident with s_req_done.
REQ-010 m_transmit  output  1  to the PCIe cfg message TX port, level.
REQ-011 m_transmit_type  output  3  registered message type.
REQ-012 m_transmit_data  output  32  registered message data.
REQ-013 m_transmit_done  input  1  completion pulse from the PCIe core.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 grant_id  output  3  index of the current or most recent grantee.
REQ-016 spurious_done  output  1  sticky; set when m_transmit_done is seen outside SEND.

Function
REQ-017 FSM states: IDLE, SEND, DONE.
REQ-018 IDLE with any s_req_valid bit high: in that cycle the arbiter SHALL select a winner by round-robin starting from rr_ptr, capture its type/data into the m_transmit_* registers, set grant_id, set rr_ptr to (winner+1) mod NUM_REQ, and go to SEND.
REQ-019 m_transmit SHALL be 1 in every SEND cycle and 0 otherwise; m_transmit_type/data SHALL stay stable throughout SEND.
REQ-020 Latency: first SEND cycle (m_transmit=1) SHALL be the cycle after s_req_valid is sampled in IDLE.
REQ-021 SEND with m_transmit_done=1 sampled: next state DONE.
REQ-022 DONE: exactly one cycle; s_req_done[grant_id]=1, all other bits 0; next state IDLE.
REQ-023 Requester handshake: type/data are captured at grant, and may change afterwards; a requester SHALL drop s_req_valid in its done cycle unless it has another message.
REQ-024 s_req_valid is not sampled in SEND or DONE; a valid drop during SEND SHALL NOT abort the message.
REQ-025 m_transmit_done in IDLE or DONE SHALL be ignored for sequencing and SHALL set spurious_done.
REQ-026 Round-robin wrap: after a grant to NUM_REQ-1, priority starts at 0.
REQ-027 With a single requester continuously valid, successive messages SHALL be granted every DONE->IDLE->SEND, i.e. minimum 3 cycles per message plus the core's done latency.

Reset
REQ-028 On aresetn=0 the arbiter SHALL go immediately to IDLE with m_transmit=0, m_transmit_type=0, m_transmit_data=0, s_req_done=0, s_req_err=0, busy=0, grant_id=0, rr_ptr=0, spurious_done=0, timeout counter=0.
REQ-029 Reset mid-SEND SHALL abort the message without any s_req_done pulse.
REQ-030 Reset deassertion SHALL take effect synchronously to aclk.

Configuration
REQ-031 Macro PCIE3_CFG_MESG_TX_ARB_TIMEOUT_EN defined: a counter SHALL clear on SEND entry and increment every SEND cycle; if it reaches TIMEOUT_CYCLES-1 without m_transmit_done, the arbiter SHALL go to DONE and pulse both s_req_done and s_req_err for the grantee.
REQ-032 If done and timeout occur in the same cycle, done SHALL win (s_req_err=0).
REQ-033 Macro undefined: no counter; SEND waits indefinitely; s_req_err is tied to 0.

Verification
REQ-034 Single request: s_req_valid=0001, type=3'b010, data=32'hDEADBEEF, done 5 cycles after m_transmit rises -> m_transmit high 1 cycle after valid, for 5 cycles; s_req_done=0001 for exactly 1 cycle; busy falls afterwards.
REQ-035 All four requesters valid continuously -> grant order 0,1,2,3,0; each grantee's data appears on m_transmit_data.
REQ-036 Requester 2 changes its data during SEND -> m_transmit_data keeps the value captured at grant.
REQ-037 m_transmit_done pulsed while in IDLE -> no state change, spurious_done=1 until reset.
REQ-038 aresetn low on the 3rd SEND cycle -> m_transmit=0 immediately, no s_req_done, rr_ptr=0 after release.
REQ-039 With the macro defined, TIMEOUT_CYCLES=16 and done never asserted -> after 16 SEND cycles, s_req_done and s_req_err pulse together; the next requester is then served.
